// File: rtl/tinker_mem_port.sv
// Dual-port pipelined byte memory: 32-bit fetch port plus 1/2/4/8-byte data port.
// Define TINKER_MEM_ALIGN_CHECK_EN to flag misaligned accesses as errors.
module tinker_mem_port #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rdata,
  output logic              d_err
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W:0] MemLimit = (ADDR_W+1)'(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  logic starve_q, starve_d;
  logic acc_if, acc_d;

  assign d_req_ready  = !(if_req_valid && starve_q);
  assign if_req_ready = !d_req_valid || starve_q;
  assign acc_d        = d_req_valid && d_req_ready;
  assign acc_if       = if_req_valid && if_req_ready;

  always_comb begin
    starve_d = starve_q;
    if (acc_if) begin
      starve_d = 1'b0;
    end else if (if_req_valid) begin
      starve_d = 1'b1;
    end
  end

  // Bounds are evaluated one bit wider than the address so wrap-around is an error.
  logic [3:0]      d_nbytes;
  logic [ADDR_W:0] if_end, d_end;
  logic            if_mis, d_mis;
  logic            if_err_c, d_err_c;

  assign d_nbytes = 4'd1 << d_size;
  assign if_end   = {1'b0, if_addr} + (ADDR_W+1)'(3);
  assign d_end    = {1'b0, d_addr} + (ADDR_W+1)'(d_nbytes) - (ADDR_W+1)'(1);

`ifdef TINKER_MEM_ALIGN_CHECK_EN
  always_comb begin
    case (d_size)
      2'd0:    d_mis = 1'b0;
      2'd1:    d_mis = d_addr[0];
      2'd2:    d_mis = |d_addr[1:0];
      default: d_mis = |d_addr[2:0];
    endcase
  end
  assign if_mis = |if_addr[1:0];
`else
  assign d_mis  = 1'b0;
  assign if_mis = 1'b0;
`endif

  assign if_err_c = (if_end >= MemLimit) || if_mis;
  assign d_err_c  = (d_end >= MemLimit) || d_mis;

  logic [IDX_W-1:0] if_idx, d_idx;
  logic [31:0]      if_rd;
  logic [63:0]      d_rd;

  assign if_idx = if_addr[IDX_W-1:0];
  assign d_idx  = d_addr[IDX_W-1:0];

  always_comb begin
    if_rd = '0;
    d_rd  = '0;
    for (int k = 0; k < 4; k++) begin
      if_rd[8*k +: 8] = mem[if_idx + IDX_W'(k)];
    end
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < d_nbytes) begin
        d_rd[8*k +: 8] = mem[d_idx + IDX_W'(k)];
      end
    end
    if (if_err_c) if_rd = '0;
    if (d_err_c || d_we) d_rd = '0;
  end

  // Array is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (acc_d && d_we && !d_err_c) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < d_nbytes) begin
          mem[d_idx + IDX_W'(k)] <= d_wdata[8*k +: 8];
        end
      end
    end
  end

  logic [LATENCY-1:0] pv_q, pp_q, pe_q;
  logic [63:0]        pd_q [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= 1'b0;
      pv_q     <= '0;
      pp_q     <= '0;
      pe_q     <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      starve_q <= starve_d;
      pv_q[0]  <= acc_d || acc_if;
      pp_q[0]  <= acc_d;
      pe_q[0]  <= acc_d ? d_err_c : if_err_c;
      pd_q[0]  <= acc_d ? d_rd : {32'h0, if_rd};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign if_rsp_valid = pv_q[LATENCY-1] && !pp_q[LATENCY-1];
  assign d_rsp_valid  = pv_q[LATENCY-1] && pp_q[LATENCY-1];
  assign if_err       = if_rsp_valid && pe_q[LATENCY-1];
  assign d_err        = d_rsp_valid && pe_q[LATENCY-1];
  assign if_rdata     = if_rsp_valid ? pd_q[LATENCY-1][31:0] : 32'h0;
  assign d_rdata      = d_rsp_valid ? pd_q[LATENCY-1] : 64'h0;

endmodule

// File: tb/tb_tinker_mem_port.sv
// Bench for tinker_mem_port: byte-array reference model with a response queue,
// plus literal expectations on the documented scenarios.
module tb_tinker_mem_port;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_BYTES = 524288;
  localparam int unsigned LATENCY   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_rsp_valid;
  logic [63:0] d_rdata;
  logic        d_err;

  tinker_mem_port #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES),
    .LATENCY  (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_addr     (if_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rdata    (if_rdata),
    .if_err      (if_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_we        (d_we),
    .d_size      (d_size),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .d_err       (d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          port;  // 1 = data, 0 = fetch
    bit          err;
    logic [63:0] data;
  } exp_t;

  exp_t        expq[$];
  bit          rsp_log[$];
  logic [7:0]  mm [int unsigned];
  bit          starve_m = 1'b0;
  int unsigned edges = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_d;
  logic [31:0] last_if;
  logic        last_d_err, last_if_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edges);
    end
  endtask

  function automatic bit range_err(input logic [31:0] a, input int unsigned n);
    bit e;
    e = (longint'(a) + longint'(n) - 1) >= longint'(MEM_BYTES);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
    if ((a % n) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [63:0] mread(input logic [31:0] a, input int unsigned n);
    logic [63:0] v = '0;
    for (int k = 0; k < int'(n); k++) begin
      v[8*k +: 8] = mm.exists(a + k) ? mm[a + k] : 8'h00;
    end
    return v;
  endfunction

  // Compare process: responses must emerge exactly when the model says, in order.
  bit   ev_d, ev_i;
  exp_t e_cur;
  always @(negedge clk) begin
    ev_d = 1'b0;
    ev_i = 1'b0;
    if (expq.size() > 0 && expq[0].due == edges) begin
      e_cur = expq.pop_front();
      if (e_cur.port) ev_d = 1'b1;
      else            ev_i = 1'b1;
    end
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'(ev_i));
    chk("d_rsp_valid", 64'(d_rsp_valid), 64'(ev_d));
    if (ev_i) begin
      chk("if_err", 64'(if_err), 64'(e_cur.err));
      chk("if_rdata", 64'(if_rdata), 64'(e_cur.data[31:0]));
    end
    if (ev_d) begin
      chk("d_err", 64'(d_err), 64'(e_cur.err));
      chk("d_rdata", d_rdata, e_cur.data);
    end
    if (if_rsp_valid) begin
      rsp_log.push_back(1'b0);
      last_if     = if_rdata;
      last_if_err = if_err;
    end
    if (d_rsp_valid) begin
      rsp_log.push_back(1'b1);
      last_d     = d_rdata;
      last_d_err = d_err;
    end
  end

  task automatic step(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                      input logic [1:0] dsz, input logic [31:0] da, input logic [63:0] dwd);
    bit          rd, ri, ad, ai, er;
    int unsigned n;
    exp_t        e;
    if_req_valid = iv;
    if_addr      = ia;
    d_req_valid  = dv;
    d_we         = dwe;
    d_size       = dsz;
    d_addr       = da;
    d_wdata      = dwd;
    #1;
    rd = !(iv && starve_m);
    ri = !dv || starve_m;
    chk("d_req_ready", 64'(d_req_ready), 64'(rd));
    chk("if_req_ready", 64'(if_req_ready), 64'(ri));
    ad = dv && rd;
    ai = iv && ri;
    n  = 1 << dsz;
    er = 1'b0;
    if (ad) begin
      er     = range_err(da, n);
      e.due  = edges + LATENCY;
      e.port = 1'b1;
      e.err  = er;
      e.data = (er || dwe) ? 64'h0 : mread(da, n);
      expq.push_back(e);
    end
    if (ai) begin
      e.due  = edges + LATENCY;
      e.port = 1'b0;
      e.err  = range_err(ia, 4);
      e.data = e.err ? 64'h0 : mread(ia, 4);
      expq.push_back(e);
    end
    @(posedge clk);
    edges++;
    if (ad && dwe && !er) begin
      for (int k = 0; k < int'(n); k++) mm[da + k] = dwd[8*k +: 8];
    end
    if (ai)      starve_m = 1'b0;
    else if (iv) starve_m = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic dload(input logic [31:0] a, input logic [1:0] sz);
    step(0, 0, 1, 0, sz, a, 0);
  endtask
  task automatic dstore(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] v);
    step(0, 0, 1, 1, sz, a, v);
  endtask
  task automatic fetch(input logic [31:0] a);
    step(1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    expq.delete();
    starve_m = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edges++;
    end
    #1;
    chk("rst if_rsp_valid", 64'(if_rsp_valid), 64'h0);
    chk("rst d_rsp_valid", 64'(d_rsp_valid), 64'h0);
    chk("rst if_err", 64'(if_err), 64'h0);
    chk("rst d_err", 64'(d_err), 64'h0);
    chk("rst if_rdata", 64'(if_rdata), 64'h0);
    chk("rst d_rdata", d_rdata, 64'h0);
    chk("rst if_req_ready", 64'(if_req_ready), 64'h1);
    chk("rst d_req_ready", 64'(d_req_ready), 64'h1);
    reset = 1'b0;
    rsp_log.delete();
  endtask

  logic [63:0] exp_200;
  logic        exp_st_err;
  bit          exp_ord [5];

  initial begin
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();

    // Basic store/load and sub-word/fetch views of the same bytes
    dstore(32'h100, 2'd3, 64'h1122334455667788);
    idle(LATENCY);
    dload(32'h100, 2'd3);
    idle(LATENCY);
    chk("lit load 0x100", last_d, 64'h1122334455667788);
    chk("lit load 0x100 err", 64'(last_d_err), 64'h0);
    dload(32'h102, 2'd1);
    idle(LATENCY);
    chk("lit load 0x102 h", last_d, 64'h0000000000005566);
    fetch(32'h100);
    idle(LATENCY);
    chk("lit fetch 0x100", 64'(last_if), 64'h55667788);

    // Contention: requests held until accepted
    rsp_log.delete();
    step(1, 32'h100, 1, 0, 2'd3, 32'h100, 0);
    step(1, 32'h100, 1, 0, 2'd1, 32'h102, 0);
    step(1, 32'h104, 1, 0, 2'd1, 32'h102, 0);
    step(1, 32'h104, 1, 0, 2'd2, 32'h104, 0);
    step(0, 0, 1, 0, 2'd2, 32'h104, 0);
    idle(LATENCY + 1);
    chk("lit order count", 64'(rsp_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < rsp_log.size(); i++) chk("lit order", 64'(rsp_log[i]), 64'(exp_ord[i]));
    chk("lit fetch 0x104", 64'(last_if), 64'h11223344);

    // Range and wrap errors
    dload(MEM_BYTES - 4, 2'd3);
    idle(LATENCY);
    chk("lit oob err", 64'(last_d_err), 64'h1);
    chk("lit oob data", last_d, 64'h0);
    dstore(MEM_BYTES - 8, 2'd3, 64'hCAFEBABE01234567);
    idle(LATENCY);
    chk("lit top store err", 64'(last_d_err), 64'h0);
    dload(MEM_BYTES - 8, 2'd3);
    dload(32'hFFFF_FFFC, 2'd3);
    idle(LATENCY);
    chk("lit wrap err", 64'(last_d_err), 64'h1);
    fetch(MEM_BYTES - 2);
    fetch(32'hFFFF_FFFE);
    idle(LATENCY);
    chk("lit fetch wrap err", 64'(last_if_err), 64'h1);

    // Misaligned word store
    dstore(32'h200, 2'd3, 64'h0807060504030201);
    dstore(32'h201, 2'd2, 64'h0000000099887766);
    idle(LATENCY);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
    exp_200    = 64'h0807060504030201;
    exp_st_err = 1'b1;
`else
    exp_200    = 64'h0807069988776601;
    exp_st_err = 1'b0;
`endif
    chk("lit unaligned store err", 64'(last_d_err), 64'(exp_st_err));
    dload(32'h200, 2'd3);
    fetch(32'h201);
    idle(LATENCY);
    chk("lit load 0x200", last_d, exp_200);

    // Reset with loads in flight
    dstore(32'h300, 2'd3, 64'hDEADBEEFCAFEF00D);
    dload(32'h100, 2'd3);
    dload(32'h200, 2'd2);
    dload(32'h300, 2'd3);
    do_reset();
    idle(LATENCY + 2);
    chk("lit no rsp after reset", 64'(rsp_log.size()), 64'd0);
    dload(32'h300, 2'd3);
    idle(LATENCY);
    chk("lit store survives reset", last_d, 64'hDEADBEEFCAFEF00D);

    idle(2);
    chk("drain", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tinker_mem_port.md
# tinker_mem_port

Dual-port, parametrised, pipelined memory for the Tinker core, replacing the single-cycle combinational byte array. It provides a 32-bit instruction-fetch port and a data port for 1/2/4/8-byte loads and stores. Both ports use valid/ready request handshakes and share one access slot per cycle through a fair arbiter. Responses return after a fixed, configurable latency and carry an error flag for illegal accesses.

## Interface
- ADDR_W, 32, byte-address width on both ports
- MEM_BYTES, 524288, memory size in bytes; legal addresses are 0 to MEM_BYTES-1
- LATENCY, 2, cycles from request acceptance to response; must be at least 1
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle when high together with valid
- if_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  fetch response valid; single-cycle pulse
- if_rdata  out  32  fetched instruction
- if_err  out  1  fetch error; qualified by if_rsp_valid
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle when high together with valid
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data; only the low 2^d_size bytes are used
- d_rsp_valid  out  1  data response valid; pulses for loads and stores
- d_rdata  out  64  load data, zero-extended; 0 for stores
- d_err  out  1  data error; qualified by d_rsp_valid

## Operation
- Byte order is little-endian. The byte at addr is bits [7:0]; addr+k is bits [8k+7:8k].
- Arbitration: at most one request is accepted per cycle.
  - The data port wins by default.
  - Sticky flag `starve`:
    - Set when if_req_valid is high and the fetch request is not accepted.
    - Cleared when a fetch request is accepted.
  - If both ports are valid and `starve` = 1, fetch wins.
  - d_req_ready = !(if_req_valid && starve).
  - if_req_ready = !d_req_valid || starve.
  - ready outputs are combinational from valid and `starve`. Requesters must hold valid and payload until accepted.
- Error conditions; an errored request performs no write and returns rdata 0:
  - Fetch: if_addr + 3 >= MEM_BYTES.
  - Data: d_addr + 2^d_size - 1 >= MEM_BYTES.
  - Compute these bounds at ADDR_W+1 bits so address wrap-around is detected as an error.
- Stores:
  - Bytes are written at the accepting clock edge.
  - A load or fetch accepted in any later cycle sees the new bytes.
- Loads and fetches: data is sampled from the array in the accepting cycle, then carried through the pipeline.
- Pipeline:
  - LATENCY stages, each holding {valid, port id, err, data}.
  - There is no response backpressure; consumers must take every response.
- Memory contents are not cleared by reset.

## Timing
- A request accepted at edge N produces its response pulse in cycle N+LATENCY, i.e. visible after edge N+LATENCY-1 through edge N+LATENCY.
- Throughput: one accepted request per cycle, either port. Responses stay in acceptance order.
- Reset values: if_rsp_valid = 0, d_rsp_valid = 0, if_err = 0, d_err = 0, if_rdata = 0, d_rdata = 0, starve = 0, all pipeline valids = 0.
  - Ready outputs follow their combinational equations, i.e. 1 when no valid is asserted.
- Reset mid-operation: all in-flight responses are discarded and never appear. A store already accepted before reset remains in memory.
- Simultaneous valids with starve = 0: data is accepted, fetch stalls, and starve is set at that edge. The next cycle, fetch is accepted.

## Configuration
- TINKER_MEM_ALIGN_CHECK_EN:
  - Defined: a data access whose d_addr is not a multiple of 2^d_size, or a fetch whose if_addr[1:0] != 0, returns err = 1, performs no write and returns rdata 0.
  - Undefined: unaligned accesses are performed normally byte-by-byte, with the range check as the only error.

## Test plan
- Store at d_addr 0x100, d_size 3, data 0x1122334455667788, then load at 0x100, size 3 → d_rdata = 0x1122334455667788 exactly LATENCY cycles after load acceptance, d_err = 0.
- Load at 0x102, size 1 after the above store → d_rdata = 0x0000000000005566. Fetch at 0x100 → if_rdata = 0x55667788.
- Both ports valid for 4 consecutive cycles → acceptance alternates data, fetch, data, fetch. Responses appear in the same order, one per cycle.
- Load at d_addr MEM_BYTES-4, size 3 → d_err = 1, d_rdata = 0. Store at MEM_BYTES-8, size 3 → d_err = 0. Load at 0xFFFFFFFC, size 3 → d_err = 1 (wrap case).
- Store size 2 at 0x201:
  - With TINKER_MEM_ALIGN_CHECK_EN: d_err = 1, and a later load at 0x200 returns the prior contents.
  - Without the macro: d_err = 0, and the write lands in bytes 0x201–0x204.
- Accept three loads, then assert reset before any response → no d_rsp_valid pulse after reset. A store accepted before the reset is still readable after reset.
